div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in the EX stage.
//  EX raises start_i with operands and holds them; EX stalls the pipeline via the stall bus until ready_o.
//  EX then forwards result_o {rem,quot} to hi/lo through ex_mem.
//  One division in flight at a time; no pipelining of requests.
// PARAMETERS
//  WIDTH  32  operand width; result_o is 2*WIDTH
//  CNT_W  6   iteration counter width; must hold the value WIDTH
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset: synchronous, active-high
//  start_i       in   1        request; held high by EX until it consumes the result
//  signed_i      in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   WIDTH    dividend; sampled only in IDLE on accepted start
//  opdata2_i     in   WIDTH    divisor; sampled only in IDLE on accepted start
//  annul_i       in   1        abort current op (only with DIV_ANNUL_EN)
//  result_o      out  2*WIDTH  {remainder, quotient}; valid while ready_o
//  ready_o       out  1        result valid (registered)
//  busy_o        out  1        state is BYZERO or ON (combinational from state)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, ready_o=0, result_o=0, internal regs=0.
//    Reset takes priority in every state, including mid-operation.
//  State machine:
//    IDLE:   start_i=1 (and annul_i=0) ->
//              divisor==0: BYZERO
//              otherwise:  ON, cnt=0, latch operands
//    BYZERO: one cycle; -> END with result_o=0, ready_o=1
//    ON:     cnt<WIDTH: one iteration per cycle, cnt++
//            cnt==WIDTH: apply sign fix, load result_o, ready_o=1, -> END
//    END:    start_i=1: hold result_o and ready_o
//            start_i=0: -> IDLE, ready_o=0, result_o=0 on the same edge
//  Operand prep for signed_i=1:
//    divisor and dividend are converted to magnitude by WIDTH-bit negate if MSB set.
//    0x80000000 magnitude is treated as unsigned 2^31.
//  Iteration: register dvd[2*WIDTH:0], initial {WIDTH'b0, |op1|, 1'b0}.
//    diff = {1'b0,dvd[2*WIDTH-1:WIDTH]} - {1'b0,|op2|}
//    diff[WIDTH]=1 (negative): dvd <= {dvd[2*WIDTH-1:0],1'b0}
//    otherwise:                dvd <= {diff[WIDTH-1:0],dvd[WIDTH-1:0],1'b1}
//  Final values: quot = dvd[WIDTH-1:0]; rem = dvd[2*WIDTH:WIDTH+1].
//  Sign fix (signed_i latched at start):
//    negate quot if op1 MSB != op2 MSB
//    negate rem if op1 MSB=1 (remainder takes the dividend's sign)
//  Latency: nonzero divisor -> ready_o high WIDTH+2 edges after start is accepted (34 for WIDTH=32).
//    Divide by zero -> ready_o high 2 edges after start is accepted.
//  Boundary cases:
//    start_i dropped during BYZERO/ON without annul: op continues; END then drops to IDLE next cycle.
//    No overflow trap: 0x80000000/-1 signed gives quot 0x80000000, rem 0.
//    start_i while already in ON/END is not a new request.
// CONFIGURATION
//  DIV_ANNUL_EN defined:
//    annul_i exists.
//    annul_i=1 in BYZERO or ON: -> IDLE, cnt=0, ready_o=0, result_o=0 next edge.
//    annul_i=1 in IDLE blocks acceptance. Ignored in END.
//  DIV_ANNUL_EN undefined:
//    annul_i is not present; only rst aborts an op.
// STRUCTURE
//  Shared defines.v entries:
//    state codes DivFree/DivByZero/DivOn/DivEnd (2 bits)
//    DivStart/DivStop
//    DivResultReady/DivResultNotReady
//    DoubleRegBus
//  Optional sub-module div_step: combinational subtract/shift of one iteration.
//    Keep FSM, counter and sign fix in div_seq.
// TESTING
//  DIVU 100/7, hold start -> ready_o after 34 cycles, result_o={32'd2,32'd14}; drop start -> ready_o=0 next cycle
//  DIV -7/2 -> quot 0xFFFFFFFD, rem 0xFFFFFFFF; DIV 7/-2 -> quot 0xFFFFFFFD, rem 0x00000001
//  DIV 0x80000000/0xFFFFFFFF -> quot 0x80000000, rem 0; DIVU 0xFFFFFFFF/1 -> quot 0xFFFFFFFF, rem 0
//  DIVU 5/0 -> busy_o 1 cycle, ready_o after 2 cycles, result_o=0
//  DIV_ANNUL_EN: annul_i at cycle 10 of ON -> IDLE, ready_o never high; next start 9/3 -> quot 3, rem 0
//  rst at cycle 20 of ON -> all outputs 0 next edge; new request afterwards completes normally

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state codes, request and
// result-ready levels, and the double-width register bus type.
package div_seq_pkg;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Request level on start_i
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Level of ready_o
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // {hi, lo} bus carrying {remainder, quotient}
    typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring division iteration: trial-subtract the divisor from
// the upper partial remainder, then shift in the new quotient bit.
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH:0]   dvd_o
);

    logic [WIDTH:0] diff_s;

    // Trial subtraction; a borrow (diff_s[WIDTH]) means the quotient bit is 0
    always_comb begin
        diff_s = {1'b0, dvd_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};
        if (diff_s[WIDTH]) begin
            dvd_o = {dvd_i[2*WIDTH-1:0], 1'b0};
        end else begin
            dvd_o = {diff_s[WIDTH-1:0], dvd_i[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU.
// Holds ready_o and {remainder, quotient} until the requester drops start_i.
// Optional feature macro: DIV_ANNUL_EN adds annul_i, which aborts an
// operation in flight and blocks acceptance while high in IDLE.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
`ifdef DIV_ANNUL_EN
    input  logic               annul_i,
`endif
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [2*WIDTH:0]   dvd_r, dvd_nxt_s, dvd_step_s;
    logic [WIDTH-1:0]   divisor_r, divisor_nxt_s;
    logic               neg_quot_r, neg_quot_nxt_s;
    logic               neg_rem_r, neg_rem_nxt_s;
    logic [2*WIDTH-1:0] result_r, result_nxt_s;
    logic               ready_r, ready_nxt_s;
    logic               annul_s;

    // Two's complement negate when cond is set
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] value,
                                                input logic cond);
        if (cond) begin
            neg_if = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            neg_if = value;
        end
    endfunction

`ifdef DIV_ANNUL_EN
    assign annul_s = annul_i;
`else
    assign annul_s = 1'b0;
`endif

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .dvd_i     (dvd_r[2*WIDTH-1:0]),
        .divisor_i (divisor_r),
        .dvd_o     (dvd_step_s)
    );

    // Next-state, counter, datapath and output selection
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        dvd_nxt_s      = dvd_r;
        divisor_nxt_s  = divisor_r;
        neg_quot_nxt_s = neg_quot_r;
        neg_rem_nxt_s  = neg_rem_r;
        result_nxt_s   = result_r;
        ready_nxt_s    = ready_r;
        case (state_r)
            DivFree: begin
                if ((start_i == DivStart) && !annul_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        state_nxt_s = DivByZero;
                    end else begin
                        state_nxt_s    = DivOn;
                        // Magnitudes: 0x80..0 stays as unsigned 2^(WIDTH-1)
                        dvd_nxt_s      = {{WIDTH{1'b0}},
                                          neg_if(opdata1_i, signed_i & opdata1_i[WIDTH-1]),
                                          1'b0};
                        divisor_nxt_s  = neg_if(opdata2_i, signed_i & opdata2_i[WIDTH-1]);
                        neg_quot_nxt_s = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_nxt_s  = signed_i & opdata1_i[WIDTH-1];
                    end
                end else begin
                    state_nxt_s = DivFree;
                end
            end
            DivByZero: begin
                if (annul_s) begin
                    state_nxt_s  = DivFree;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    ready_nxt_s  = DivResultNotReady;
                    result_nxt_s = {(2*WIDTH){1'b0}};
                end else begin
                    state_nxt_s  = DivEnd;
                    ready_nxt_s  = DivResultReady;
                    result_nxt_s = {(2*WIDTH){1'b0}};
                end
            end
            DivOn: begin
                if (annul_s) begin
                    state_nxt_s  = DivFree;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    ready_nxt_s  = DivResultNotReady;
                    result_nxt_s = {(2*WIDTH){1'b0}};
                end else if (cnt_r == CntLast) begin
                    state_nxt_s  = DivEnd;
                    ready_nxt_s  = DivResultReady;
                    result_nxt_s = {neg_if(dvd_r[2*WIDTH:WIDTH+1], neg_rem_r),
                                    neg_if(dvd_r[WIDTH-1:0], neg_quot_r)};
                end else begin
                    dvd_nxt_s = dvd_step_s;
                    cnt_nxt_s = cnt_r + CntOne;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_nxt_s  = DivFree;
                    ready_nxt_s  = DivResultNotReady;
                    result_nxt_s = {(2*WIDTH){1'b0}};
                end else begin
                    state_nxt_s = DivEnd;
                end
            end
            default: begin
                state_nxt_s  = DivFree;
                cnt_nxt_s    = {CNT_W{1'b0}};
                ready_nxt_s  = DivResultNotReady;
                result_nxt_s = {(2*WIDTH){1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DivFree;
            cnt_r      <= {CNT_W{1'b0}};
            dvd_r      <= {(2*WIDTH+1){1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_r   <= {(2*WIDTH){1'b0}};
            ready_r    <= DivResultNotReady;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            dvd_r      <= dvd_nxt_s;
            divisor_r  <= divisor_nxt_s;
            neg_quot_r <= neg_quot_nxt_s;
            neg_rem_r  <= neg_rem_nxt_s;
            result_r   <= result_nxt_s;
            ready_r    <= ready_nxt_s;
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;
    assign busy_o   = (state_r == DivByZero) || (state_r == DivOn);

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=32).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
`ifdef DIV_ANNUL_EN
    logic        annul_i;
`endif
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
`ifdef DIV_ANNUL_EN
        .annul_i   (annul_i),
`endif
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Raise a request at a negedge and count edges until ready_o (max 100)
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_o) break;
        end
    endtask

    // Drop the request and let END return to IDLE
    task automatic release_req();
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
`ifdef DIV_ANNUL_EN
        annul_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b busy=%b result=%h expected 0/0/0", ready_o, busy_o, result_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        int lat;
        run_op(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL divu_latency: got %0d expected 34", lat);
        end
        checks++;
        if (result_o !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_100_7: got %h expected %h", result_o, {32'd2, 32'd14});
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL divu_busy_end: got %b expected 0", busy_o);
        end
        // Held start with new operands is not a new request
        opdata1_i = 32'd55; opdata2_i = 32'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_hold: ready=%b result=%h expected 1/%h", ready_o, result_o, {32'd2, 32'd14});
        end
        release_req();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL divu_drop: ready=%b result=%h expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        logic        sg [6];
        logic [31:0] a  [6];
        logic [31:0] b  [6];
        logic [63:0] ex [6];
        int lat;
        sg[0] = 1'b1; a[0] = 32'hFFFFFFF9; b[0] = 32'd2;        ex[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
        sg[1] = 1'b1; a[1] = 32'd7;        b[1] = 32'hFFFFFFFE; ex[1] = {32'h00000001, 32'hFFFFFFFD};
        sg[2] = 1'b1; a[2] = 32'h80000000; b[2] = 32'hFFFFFFFF; ex[2] = {32'h00000000, 32'h80000000};
        sg[3] = 1'b0; a[3] = 32'hFFFFFFFF; b[3] = 32'd1;        ex[3] = {32'h00000000, 32'hFFFFFFFF};
        sg[4] = 1'b1; a[4] = 32'hFFFFFFF9; b[4] = 32'hFFFFFFFE; ex[4] = {32'hFFFFFFFF, 32'h00000003};
        sg[5] = 1'b0; a[5] = 32'hFFFFFFF9; b[5] = 32'd2;        ex[5] = {32'h00000001, 32'h7FFFFFFC};
        for (int i = 0; i < 6; i++) begin
            run_op(sg[i], a[i], b[i], lat);
            checks++;
            if (lat !== 34 || result_o !== ex[i]) begin
                failures++;
                $display("FAIL signed_vec%0d: lat=%0d result=%h expected 34/%h", i, lat, result_o, ex[i]);
            end
            release_req();
        end
    endtask

    task automatic test_div_zero();
        signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL divzero_c1: busy=%b ready=%b expected 1/0", busy_o, ready_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL divzero_c2: busy=%b ready=%b result=%h expected 0/1/0", busy_o, ready_o, result_o);
        end
        release_req();
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL divzero_drop: ready=%b expected 0", ready_o);
        end
    endtask

    task automatic test_start_drop();
        int lat;
        signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd9; start_i = 1'b1;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        lat = 5;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_o) break;
        end
        checks++;
        if (lat !== 34 || result_o !== {32'd1, 32'd111}) begin
            failures++;
            $display("FAIL drop_result: lat=%0d result=%h expected 34/%h", lat, result_o, {32'd1, 32'd111});
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle: ready=%b busy=%b result=%h expected 0/0/0", ready_o, busy_o, result_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (21) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy: got %b expected 1", busy_o);
        end
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: ready=%b busy=%b result=%h expected 0/0/0", ready_o, busy_o, result_o);
        end
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, lat);
        checks++;
        if (lat !== 34 || result_o !== {32'd0, 32'd3}) begin
            failures++;
            $display("FAIL rstmid_next: lat=%0d result=%h expected 34/%h", lat, result_o, {32'd0, 32'd3});
        end
        release_req();
    endtask

`ifdef DIV_ANNUL_EN
    task automatic test_annul();
        int lat;
        int seen;
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL annul_abort: busy=%b ready=%b result=%h expected 0/0/0", busy_o, ready_o, result_o);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL annul_noready: got %0d ready cycles expected 0", seen);
        end
        // annul held in IDLE blocks acceptance
        annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL annul_block: busy=%b expected 0", busy_o);
        end
        annul_i = 1'b0;
        run_op(1'b0, 32'd9, 32'd3, lat);
        checks++;
        if (lat !== 34 || result_o !== {32'd0, 32'd3}) begin
            failures++;
            $display("FAIL annul_next: lat=%0d result=%h expected 34/%h", lat, result_o, {32'd0, 32'd3});
        end
        release_req();
    endtask
`endif

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_start_drop();
        test_reset_mid();
`ifdef DIV_ANNUL_EN
        test_annul();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
